// File: rtl/router_pkg.sv
// router_pkg: shared state enum, address widths and block-size helper for the cluster routers.
package router_pkg;
  typedef enum logic [1:0] {IDLE, READ_SPAD, DRAIN, DONE} psum_state_e;
  localparam int GLB_AW = 10;
  localparam int SPAD_AW = 9;
  localparam int CNT_W = 8;
  function automatic int psum_count(input int act_size, input int kernel_size);
    return (act_size - kernel_size + 1) ** 2;
  endfunction
endpackage

// File: rtl/router_psum_wb.sv
// router_psum_wb: streams a psum block from the PE spad to consecutive GLB addresses.
// Optional ROUTER_PSUM_RELU_EN clamps negative words to zero in the capture stage.
module router_psum_wb
  import router_pkg::*;
#(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH_GLB = GLB_AW,
  parameter int ADDR_BITWIDTH_SPAD = SPAD_AW,
  parameter int kernel_size = 3,
  parameter int act_size = 5,
  parameter int P_WRITE_ADDR = 500,
  parameter int P_READ_ADDR_SPAD = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITWIDTH-1:0]      r_data_spad_psum,
  output logic [ADDR_BITWIDTH_SPAD-1:0] r_addr_spad_psum,
  output logic                          read_req_spad_psum,
  output logic [DATA_BITWIDTH-1:0]      w_data_glb_psum,
  output logic [ADDR_BITWIDTH_GLB-1:0]  w_addr_glb_psum,
  output logic                          write_en_glb_psum,
  input  logic                          write_psum_ctrl,
  output logic                          write_done
);
  localparam logic [CNT_W-1:0] N = CNT_W'(psum_count(act_size, kernel_size));
  localparam logic [ADDR_BITWIDTH_GLB-1:0] WBASE = ADDR_BITWIDTH_GLB'(P_WRITE_ADDR);
  localparam logic [ADDR_BITWIDTH_SPAD-1:0] RBASE = ADDR_BITWIDTH_SPAD'(P_READ_ADDR_SPAD);
  psum_state_e state_q, state_d;
  logic [CNT_W-1:0] rd_count_q, rd_count_d, wr_count_q, wr_count_d;
  logic [ADDR_BITWIDTH_SPAD-1:0] raddr_q, raddr_d;
  logic [ADDR_BITWIDTH_GLB-1:0] waddr_q, waddr_d;
  logic [DATA_BITWIDTH-1:0] wdata_q, wdata_d;
  logic req_q, req_d, vld_q, vld_d, wen_q, wen_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    raddr_d = raddr_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    vld_d = req_q;
    wen_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (write_psum_ctrl) begin
        state_d = READ_SPAD;
        req_d = 1'b1;
        raddr_d = RBASE;
        rd_count_d = 8'd1;
        wr_count_d = '0;
      end
      READ_SPAD: if (rd_count_q < N) begin
        raddr_d = raddr_q + ADDR_BITWIDTH_SPAD'(1);
        rd_count_d = rd_count_q + 8'd1;
      end else begin
        req_d = 1'b0;
        state_d = DRAIN;
      end
      DRAIN: if (wr_count_q == N) begin
        state_d = DONE;
        done_d = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // spad data arrives one cycle after its request; register it as a GLB write
    if (vld_q && (state_q == READ_SPAD || state_q == DRAIN)) begin
      wen_d = 1'b1;
      waddr_d = WBASE + ADDR_BITWIDTH_GLB'(wr_count_q);
      wr_count_d = wr_count_q + 8'd1;
`ifdef ROUTER_PSUM_RELU_EN
      wdata_d = r_data_spad_psum[DATA_BITWIDTH-1] ? '0 : r_data_spad_psum;
`else
      wdata_d = r_data_spad_psum;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q <= 1'b0;
      raddr_q <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      vld_q <= 1'b0;
      wen_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      raddr_q <= raddr_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      vld_q <= vld_d;
      wen_q <= wen_d;
      done_q <= done_d;
    end
  end
  assign r_addr_spad_psum = raddr_q;
  assign read_req_spad_psum = req_q;
  assign w_addr_glb_psum = waddr_q;
  assign w_data_glb_psum = wdata_q;
  assign write_en_glb_psum = wen_q;
  assign write_done = done_q;
endmodule

// File: tb/tb_router_psum_wb.sv
// tb_router_psum_wb: directed checks of the psum write-back router, default and 4x4/1x1 geometry.
module tb_router_psum_wb;
  logic clk = 1'b0;
  logic rst1, rst2, go1, go2, req1, req2, wen1, wen2, done1, done2;
  logic [15:0] rd1 = '0, rd2 = '0, wd1, wd2;
  logic [8:0] ra1, ra2;
  logic [9:0] wa1, wa2;
  logic [15:0] spad1 [512];
  logic [15:0] spad2 [512];
  logic [15:0] glb1 [1024];
  int n_cmp = 0, n_err = 0;
`ifdef ROUTER_PSUM_RELU_EN
  localparam logic [15:0] NEG_EXP = 16'h0000;
`else
  localparam logic [15:0] NEG_EXP = 16'hFFFE;
`endif
  typedef struct {
    logic req;
    logic [8:0] ra;
    logic wen;
    logic [9:0] wa;
    logic [15:0] wd;
    logic done;
  } vec_t;
  vec_t v [15];

  router_psum_wb u1 (
    .clk(clk), .reset(rst1), .r_data_spad_psum(rd1), .r_addr_spad_psum(ra1),
    .read_req_spad_psum(req1), .w_data_glb_psum(wd1), .w_addr_glb_psum(wa1),
    .write_en_glb_psum(wen1), .write_psum_ctrl(go1), .write_done(done1)
  );
  router_psum_wb #(.act_size(4), .kernel_size(1), .P_WRITE_ADDR(1000)) u2 (
    .clk(clk), .reset(rst2), .r_data_spad_psum(rd2), .r_addr_spad_psum(ra2),
    .read_req_spad_psum(req2), .w_data_glb_psum(wd2), .w_addr_glb_psum(wa2),
    .write_en_glb_psum(wen2), .write_psum_ctrl(go2), .write_done(done2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (req1) rd1 <= spad1[ra1];
    if (req2) rd2 <= spad2[ra2];
    if (wen1) glb1[wa1] <= wd1;
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_basic(input string tag);
    go1 = 1'b1;
    tick();
    go1 = 1'b0;
    for (int c = 1; c < 15; c++) begin
      chk($sformatf("%s req c%0d", tag, c), 32'(req1), 32'(v[c].req));
      if (v[c].req) chk($sformatf("%s raddr c%0d", tag, c), 32'(ra1), 32'(v[c].ra));
      chk($sformatf("%s wen c%0d", tag, c), 32'(wen1), 32'(v[c].wen));
      if (v[c].wen) begin
        chk($sformatf("%s waddr c%0d", tag, c), 32'(wa1), 32'(v[c].wa));
        chk($sformatf("%s wdata c%0d", tag, c), 32'(wd1), 32'(v[c].wd));
      end
      chk($sformatf("%s done c%0d", tag, c), 32'(done1), 32'(v[c].done));
      tick();
    end
  endtask

  initial begin
    for (int c = 0; c < 15; c++) begin
      v[c].req = c >= 1 && c <= 9;
      v[c].ra = 9'(c - 1);
      v[c].wen = c >= 3 && c <= 11;
      v[c].wa = 10'(500 + c - 3);
      v[c].wd = 16'(c - 2);
      v[c].done = c == 12;
    end
    for (int i = 0; i < 512; i++) begin
      spad1[i] = (i < 9) ? 16'(i + 1) : 16'h0;
      spad2[i] = 16'(16'h100 + i);
    end
    for (int i = 0; i < 1024; i++) glb1[i] = 16'hDEAD;
    rst1 = 1'b0; rst2 = 1'b0; go1 = 1'b0; go2 = 1'b0;
    tick(); tick();
    chk("rst req", 32'(req1), 0);
    chk("rst wen", 32'(wen1), 0);
    chk("rst done", 32'(done1), 0);
    chk("rst raddr", 32'(ra1), 0);
    chk("rst waddr", 32'(wa1), 0);
    chk("rst wdata", 32'(wd1), 0);
    chk("rst2 req", 32'(req2), 0);
    chk("rst2 done", 32'(done2), 0);
    rst1 = 1'b1; rst2 = 1'b1;
    tick();
    run_basic("basic");
    for (int i = 0; i < 9; i++) chk($sformatf("basic glb%0d", 500 + i), 32'(glb1[500 + i]), 32'(i + 1));
    // start held high: second transfer sampled in cycle 13, reads 14..22
    go1 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk($sformatf("hold req c%0d", c), 32'(req1), 32'((c >= 1 && c <= 9) || (c >= 14 && c <= 22)));
      chk($sformatf("hold done c%0d", c), 32'(done1), 32'(c == 12));
    end
    go1 = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    go1 = 1'b1;
    tick();
    go1 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst1 = 1'b0;
    tick();
    chk("abort req", 32'(req1), 0);
    chk("abort wen", 32'(wen1), 0);
    chk("abort done", 32'(done1), 0);
    chk("abort raddr", 32'(ra1), 0);
    chk("abort waddr", 32'(wa1), 0);
    chk("abort wdata", 32'(wd1), 0);
    rst1 = 1'b1;
    for (int c = 0; c < 15; c++) begin
      chk($sformatf("abort quiet wen%0d", c), 32'(wen1), 0);
      chk($sformatf("abort quiet done%0d", c), 32'(done1), 0);
      tick();
    end
    spad1[2] = 16'hFFFE;
    v[5].wd = NEG_EXP;
    for (int i = 500; i < 509; i++) glb1[i] = 16'hDEAD;
    run_basic("fresh");
    for (int i = 0; i < 9; i++)
      chk($sformatf("fresh glb%0d", 500 + i), 32'(glb1[500 + i]), (i == 2) ? 32'(NEG_EXP) : 32'(i + 1));
    go2 = 1'b1;
    tick();
    go2 = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      chk($sformatf("geo wen c%0d", c), 32'(wen2), 32'(c >= 3 && c <= 18));
      if (c >= 3 && c <= 18) begin
        chk($sformatf("geo waddr c%0d", c), 32'(wa2), 32'(1000 + c - 3));
        chk($sformatf("geo wdata c%0d", c), 32'(wd2), 32'(16'h100 + c - 3));
      end
      chk($sformatf("geo done c%0d", c), 32'(done2), 32'(c == 19));
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
